// File: rtl/frac_cegen_pkg.sv
// Shared types, SCV default ratios and the config validity check for the
// fractional clock-enable generator.
package frac_cegen_pkg;

    localparam int CEGEN_W  = 10;
    localparam int CEGEN_PW = 2;

    typedef struct packed {
        logic [CEGEN_W-1:0] mul;
        logic [CEGEN_W-1:0] div;
        logic [CEGEN_PW:0]  nph;
    } cegen_cfg_t;

    localparam cegen_cfg_t CEGEN_CPU4 = '{mul: 10'd88, div: 10'd315, nph: 3'd4};
    localparam cegen_cfg_t CEGEN_AUD  = '{mul: 10'd22, div: 10'd105, nph: 3'd1};
    localparam cegen_cfg_t CEGEN_VDC  = '{mul: 10'd1,  div: 10'd7,   nph: 3'd1};

    // Width-agnostic check so channels with non-default W/PW can share it.
    function automatic logic cegen_valid(input logic [31:0] mul,
                                         input logic [31:0] div,
                                         input logic [31:0] nph,
                                         input logic [31:0] max_nph);
        return (mul != 0) && (div != 0) && (mul <= div) &&
               (nph != 0) && (nph <= max_nph);
    endfunction

    function automatic logic cegen_cfg_valid(input cegen_cfg_t c);
        return cegen_valid(32'(c.mul), 32'(c.div), 32'(c.nph), 32'(1 << CEGEN_PW));
    endfunction

endpackage

// File: rtl/frac_cegen_if.sv
// Config, control and pulse bundle between the enable generator and its users.
interface frac_cegen_if #(
    parameter int NCH = 4,
    parameter int W   = 10,
    parameter int PW  = 2,
    parameter int CW  = (NCH > 1) ? $clog2(NCH) : 1
);
    logic              CFG_WE;
    logic [CW-1:0]     CFG_CH;
    logic [W-1:0]      CFG_MUL;
    logic [W-1:0]      CFG_DIV;
    logic [PW:0]       CFG_NPH;
    logic              SYNC;
    logic [NCH-1:0]    RUN;
    logic [NCH-1:0]    CE;
    logic [NCH*PW-1:0] PHASE;
    logic [NCH-1:0]    CFG_ERR;
    logic [NCH-1:0]    PEND;

    modport master (
        output CFG_WE, CFG_CH, CFG_MUL, CFG_DIV, CFG_NPH, SYNC, RUN,
        input  CE, PHASE, CFG_ERR, PEND
    );

    modport slave (
        input  CFG_WE, CFG_CH, CFG_MUL, CFG_DIV, CFG_NPH, SYNC, RUN,
        output CE, PHASE, CFG_ERR, PEND
    );
endinterface

// File: rtl/frac_cegen_ch.sv
// One fractional-enable channel: accumulator, phase counter and an
// active/shadow config pair that switches only at pulse or idle boundaries.
module frac_cegen_ch
    import frac_cegen_pkg::*;
#(
    parameter int W  = CEGEN_W,
    parameter int PW = CEGEN_PW
) (
    input  logic          CLK,
    input  logic          RES,
    input  logic          sync,
    input  logic          run,
    input  logic          wr_en,
    input  logic [W-1:0]  wr_mul,
    input  logic [W-1:0]  wr_div,
    input  logic [PW:0]   wr_nph,
    output logic          ce,
    output logic [PW-1:0] phase_out,
    output logic          cfg_err,
    output logic          pend
);

    localparam logic [W-1:0]  ONE_W   = W'(1);
    localparam logic [PW-1:0] ONE_PH  = PW'(1);
    localparam logic [PW:0]   ONE_NPH = (PW+1)'(1);
    localparam logic [PW:0]   MAX_NPH = {1'b1, {PW{1'b0}}};

    logic [W-1:0]  acc, act_mul, act_div, shd_mul, shd_div;
    logic [PW:0]   act_nph, shd_nph;
    logic [PW-1:0] phase, phase_cnt;
    logic [W:0]    nxt, acc_cnt;
    logic          act_ok, shd_ok, hit, apply;

    always_comb begin
        act_ok    = cegen_valid(32'(act_mul), 32'(act_div), 32'(act_nph), 32'(MAX_NPH));
        shd_ok    = cegen_valid(32'(shd_mul), 32'(shd_div), 32'(shd_nph), 32'(MAX_NPH));
        nxt       = {1'b0, acc} + {1'b0, act_mul};
        hit       = run && act_ok && (nxt >= {1'b0, act_div});
        acc_cnt   = {1'b0, acc};
        phase_cnt = phase;
        if (run && act_ok) begin
            acc_cnt = hit ? (nxt - {1'b0, act_div}) : nxt;
            if (hit) begin
                phase_cnt = ({1'b0, phase} == (act_nph - ONE_NPH)) ? '0 : (phase + ONE_PH);
            end
        end
        // Switch configs only where no pulse can be split: on a hit, or when idle.
        apply = pend && (hit || !run || !act_ok);
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            acc       <= '0;
            phase     <= '0;
            ce        <= 1'b0;
            phase_out <= '0;
            cfg_err   <= 1'b0;
            pend      <= 1'b0;
            act_mul   <= ONE_W;
            act_div   <= ONE_W;
            act_nph   <= MAX_NPH;
            shd_mul   <= ONE_W;
            shd_div   <= ONE_W;
            shd_nph   <= MAX_NPH;
        end else begin
            if (sync) begin
                acc   <= '0;
                phase <= '0;
                ce    <= 1'b0;
                if (pend) begin
                    act_mul <= shd_mul;
                    act_div <= shd_div;
                    act_nph <= shd_nph;
                    cfg_err <= !shd_ok;
                end
                pend <= 1'b0;
            end else begin
                ce    <= hit;
                acc   <= acc_cnt[W-1:0];
                phase <= phase_cnt;
                if (hit) begin
                    phase_out <= phase;
                end
                if (apply) begin
                    act_mul <= shd_mul;
                    act_div <= shd_div;
                    act_nph <= shd_nph;
                    cfg_err <= !shd_ok;
                    pend    <= 1'b0;
                    if (acc_cnt >= {1'b0, shd_div}) begin
                        acc <= '0;
                    end
                    if ({1'b0, phase_cnt} >= shd_nph) begin
                        phase <= '0;
                    end
                end
            end
            // A write always lands in the shadow, even over a same-edge apply.
            if (wr_en) begin
                shd_mul <= wr_mul;
                shd_div <= wr_div;
                shd_nph <= wr_nph;
                pend    <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/frac_cegen.sv
// Multi-channel fractional clock-enable generator: decodes config writes,
// fans out SYNC/RUN and packs per-channel results onto the bus.
module frac_cegen
    import frac_cegen_pkg::*;
#(
    parameter int NCH = 4,
    parameter int W   = CEGEN_W,
    parameter int PW  = CEGEN_PW
) (
    input logic         CLK,
    input logic         RES,
    frac_cegen_if.slave bus
);

    logic          ce_a   [NCH];
    logic [PW-1:0] ph_a   [NCH];
    logic          err_a  [NCH];
    logic          pend_a [NCH];

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic wr_sel;

        // Channel numbers at or above NCH match no instance, so those writes vanish.
        assign wr_sel = bus.CFG_WE && (32'(bus.CFG_CH) == g);

        frac_cegen_ch #(
            .W  (W),
            .PW (PW)
        ) u_ch (
            .CLK       (CLK),
            .RES       (RES),
            .sync      (bus.SYNC),
            .run       (bus.RUN[g]),
            .wr_en     (wr_sel),
            .wr_mul    (bus.CFG_MUL),
            .wr_div    (bus.CFG_DIV),
            .wr_nph    (bus.CFG_NPH),
            .ce        (ce_a[g]),
            .phase_out (ph_a[g]),
            .cfg_err   (err_a[g]),
            .pend      (pend_a[g])
        );
    end

    always_comb begin
        bus.CE      = '0;
        bus.PHASE   = '0;
        bus.CFG_ERR = '0;
        bus.PEND    = '0;
        for (int i = 0; i < NCH; i++) begin
            bus.CE[i]              = ce_a[i];
            bus.PHASE[i*PW +: PW]  = ph_a[i];
            bus.CFG_ERR[i]         = err_a[i];
            bus.PEND[i]            = pend_a[i];
        end
    end

endmodule

// File: tb/tb_frac_cegen.sv
// Directed bench for frac_cegen: defaults, 88/315 rate, glitch-free ratio
// switch, invalid configs, SYNC alignment and reset during a pulse.
module tb_frac_cegen;
    import frac_cegen_pkg::*;

    localparam int NCH = 4;
    localparam int W   = 10;
    localparam int PW  = 2;

    logic CLK = 1'b0;
    logic RES = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    int   pulses, last_hit, first_hit, bad_gap, bad_ph;

    frac_cegen_if #(.NCH(NCH), .W(W), .PW(PW)) bus ();

    frac_cegen #(.NCH(NCH), .W(W), .PW(PW)) dut (
        .CLK (CLK),
        .RES (RES),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [1:0] ch,
                                 input logic [W-1:0] mul, input logic [W-1:0] div,
                                 input logic [PW:0] nph, input logic sync,
                                 input logic [NCH-1:0] run);
        bus.CFG_WE  = we;
        bus.CFG_CH  = ch;
        bus.CFG_MUL = mul;
        bus.CFG_DIV = div;
        bus.CFG_NPH = nph;
        bus.SYNC    = sync;
        bus.RUN     = run;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [PW-1:0] ph(input int c);
        return bus.PHASE[c*PW +: PW];
    endfunction

    initial begin
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0000);
        RES = 1'b1;
        tick();
        tick();
        RES = 1'b0;
        checkOutput("rst_ce", 32'(bus.CE), 0);
        checkOutput("rst_pend", 32'(bus.PEND), 0);
        checkOutput("rst_err", 32'(bus.CFG_ERR), 0);
        checkOutput("rst_phase", 32'(bus.PHASE), 0);

        // Default 1/1, four phases: a pulse every cycle, phase walking 0..3.
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0001);
        for (int k = 0; k < 5; k++) begin
            tick();
            checkOutput($sformatf("dflt_ce%0d", k), 32'(bus.CE), 32'h1);
            checkOutput($sformatf("dflt_ph%0d", k), 32'(ph(0)), 32'(k % 4));
        end
        checkOutput("dflt_err", 32'(bus.CFG_ERR), 0);

        // CPU ratio 88/315 aligned by SYNC.
        applyStimulus(1, 0, 88, 315, 4, 0, 4'b0001);
        tick();
        checkOutput("cpu_pend_set", 32'(bus.PEND), 32'h1);
        applyStimulus(0, 0, 0, 0, 0, 1, 4'b0001);
        tick();
        checkOutput("cpu_pend_sync", 32'(bus.PEND), 0);
        checkOutput("cpu_ce_sync", 32'(bus.CE), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0001);
        pulses = 0; last_hit = -1; first_hit = -1; bad_gap = 0; bad_ph = 0;
        for (int k = 1; k <= 315; k++) begin
            tick();
            if (bus.CE[0]) begin
                if (last_hit >= 0 && ((k - last_hit) < 3 || (k - last_hit) > 4)) bad_gap++;
                if (first_hit < 0) first_hit = k;
                if (32'(ph(0)) != 32'(pulses % 4)) bad_ph++;
                pulses++;
                last_hit = k;
            end
        end
        checkOutput("cpu_pulses", 32'(pulses), 88);
        checkOutput("cpu_first", 32'(first_hit), 4);
        checkOutput("cpu_gaps", 32'(bad_gap), 0);
        checkOutput("cpu_phase", 32'(bad_ph), 0);

        // Ch1: 22/105 then switch to 1/2 mid-interval.
        applyStimulus(1, 1, 22, 105, 4, 0, 4'b0000);
        tick();
        checkOutput("aud_pend_set", 32'(bus.PEND), 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0000);
        tick();
        checkOutput("aud_pend_idle", 32'(bus.PEND), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0010);
        for (int k = 0; k < 4; k++) tick();
        checkOutput("aud_ce_e4", 32'(bus.CE), 0);
        tick();
        checkOutput("aud_ce_e5", 32'(bus.CE), 32'h2);
        applyStimulus(1, 1, 1, 2, 4, 0, 4'b0010);
        tick();
        checkOutput("sw_ce_e6", 32'(bus.CE), 0);
        checkOutput("sw_pend_e6", 32'(bus.PEND), 32'h2);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0010);
        tick();
        tick();
        tick();
        checkOutput("sw_ce_e9", 32'(bus.CE), 0);
        checkOutput("sw_pend_e9", 32'(bus.PEND), 32'h2);
        tick();
        checkOutput("sw_ce_e10", 32'(bus.CE), 32'h2);
        checkOutput("sw_pend_e10", 32'(bus.PEND), 0);
        checkOutput("sw_ph_e10", 32'(ph(1)), 1);
        for (int k = 11; k <= 14; k++) begin
            tick();
            checkOutput($sformatf("half_ce_e%0d", k), 32'(bus.CE), (k % 2 == 0) ? 32'h2 : 32'h0);
        end
        checkOutput("half_ph_e14", 32'(ph(1)), 3);

        // Ch2 invalid configs: MUL=0, then MUL>DIV, then recover with 1/1.
        applyStimulus(1, 2, 0, 5, 4, 0, 4'b0100);
        tick();
        checkOutput("inv_pend_a", 32'(bus.PEND), 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100);
        tick();
        checkOutput("inv_err_b", 32'(bus.CFG_ERR), 32'h4);
        tick();
        checkOutput("inv_ce_c", 32'(bus.CE), 0);
        applyStimulus(1, 2, 5, 3, 4, 0, 4'b0100);
        tick();
        checkOutput("inv_pend_d", 32'(bus.PEND), 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100);
        tick();
        checkOutput("inv_pend_e", 32'(bus.PEND), 0);
        checkOutput("inv_err_e", 32'(bus.CFG_ERR), 32'h4);
        tick();
        checkOutput("inv_ce_e1", 32'(bus.CE), 0);
        applyStimulus(1, 2, 1, 1, 4, 0, 4'b0100);
        tick();
        checkOutput("fix_pend_f", 32'(bus.PEND), 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100);
        tick();
        checkOutput("fix_err_g", 32'(bus.CFG_ERR), 0);
        checkOutput("fix_pend_g", 32'(bus.PEND), 0);
        checkOutput("fix_ce_g", 32'(bus.CE), 0);
        tick();
        checkOutput("fix_ce_h", 32'(bus.CE), 32'h4);

        // Ch0 and ch1 at 1/3 with unrelated history, then realigned by SYNC.
        applyStimulus(1, 0, 1, 3, 4, 0, 4'b0010);
        tick();
        applyStimulus(1, 1, 1, 3, 4, 0, 4'b0010);
        tick();
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0011);
        for (int k = 0; k < 7; k++) tick();
        applyStimulus(0, 0, 0, 0, 0, 1, 4'b0011);
        tick();
        checkOutput("sync_ce_0", 32'(bus.CE), 0);
        checkOutput("sync_pend", 32'(bus.PEND), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0011);
        tick();
        checkOutput("sync_ce_1", 32'(bus.CE), 0);
        tick();
        checkOutput("sync_ce_2", 32'(bus.CE), 0);
        tick();
        checkOutput("sync_ce_3", 32'(bus.CE), 32'h3);
        checkOutput("sync_ph0", 32'(ph(0)), 0);
        checkOutput("sync_ph1", 32'(ph(1)), 0);

        // Reset landing on a pulse while a new ratio is pending.
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100);
        tick();
        applyStimulus(1, 2, 2, 3, 4, 0, 4'b0100);
        tick();
        checkOutput("res_pre_ce", 32'(bus.CE), 32'h4);
        checkOutput("res_pre_pend", 32'(bus.PEND), 32'h4);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0100);
        RES = 1'b1;
        tick();
        RES = 1'b0;
        checkOutput("res_ce", 32'(bus.CE), 0);
        checkOutput("res_pend", 32'(bus.PEND), 0);
        checkOutput("res_phase", 32'(bus.PHASE), 0);
        checkOutput("res_err", 32'(bus.CFG_ERR), 0);
        applyStimulus(0, 0, 0, 0, 0, 0, 4'b0101);
        tick();
        checkOutput("post_res_ce1", 32'(bus.CE), 32'h5);
        checkOutput("post_res_ph1", 32'(bus.PHASE), 0);
        tick();
        checkOutput("post_res_ce2", 32'(bus.CE), 32'h5);
        checkOutput("post_res_ph2", 32'(bus.PHASE), 32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/frac_cegen.md
Name: frac_cegen

Overview:
- Multi-channel fractional clock-enable generator; parametrised successor to the fixed-ratio CPU/VDC/audio enable generator in the SCV top level.
- Each channel produces single-cycle CE pulses at an average rate of CLK * MUL / DIV, plus a modulo phase index, so one channel can drive a multi-phase CPU clock.
- Ratios are runtime-programmable with glitch-free switchover, and a SYNC input phase-aligns all channels.
- Sits beside the CPU, VDC and APU in the top level; serves that top level and future cores (e.g. PAL timing, turbo mode).

Parameters:
NCH, 4, number of independent channels
W, 10, accumulator / MUL / DIV width in bits
PW, 2, phase index width; maximum phase count is 2^PW

Ports:
CLK  in  1  system clock (2 * video XTAL)
RES  in  1  synchronous reset, active-high
CFG_WE  in  1  config write strobe, one cycle
CFG_CH  in  $clog2(NCH)  target channel of write
CFG_MUL  in  W  numerator
CFG_DIV  in  W  denominator
CFG_NPH  in  PW+1  phase modulus, 1..2^PW
SYNC  in  1  realign all channels
RUN  in  NCH  per-channel run enable
CE  out  NCH  enable pulse, registered
PHASE  out  NCH*PW  phase index of the current CE pulse, channel i at [i*PW +: PW]
CFG_ERR  out  NCH  active config is invalid
PEND  out  NCH  shadow config awaiting apply

Behaviour:
- Reset (RES=1 at an edge):
  - acc=0, phase=0, CE=0, PHASE=0, PEND=0, CFG_ERR=0.
  - Active and shadow config set to MUL=1, DIV=1, NPH=2^PW.
- Priority at each edge: RES > SYNC > config apply > normal counting.
- Normal counting, per channel, with RUN[i]=1 and the active config valid:
  - nxt = acc + MUL, computed in W+1 bits (no overflow).
  - hit = (nxt >= DIV).
  - acc <= hit ? nxt - DIV : nxt.
  - CE[i] <= hit.
  - On hit: PHASE[i] <= phase, and phase <= (phase == NPH-1) ? 0 : phase+1.
  - Average rate is exactly MUL/DIV. Pulse spacing is floor(DIV/MUL) or ceil(DIV/MUL) cycles.
- Latency: the edge that samples RUN high and hit=1 sets CE. With MUL=DIV, CE is high in every cycle after the first sampling edge.
- Stopped or invalid:
  - RUN[i]=0: CE[i] <= 0; acc and phase hold (pause, not reset).
  - Invalid config: CE[i] <= 0; acc and phase hold.
- Validity:
  - Config is invalid when MUL==0, DIV==0, MUL>DIV, NPH==0 or NPH>2^PW.
  - CFG_ERR[i] reflects the active config and is registered, updating on the edge the config becomes active.
- Config write:
  - CFG_WE loads the shadow registers of CFG_CH and sets PEND[CFG_CH] on the same edge.
  - CFG_CH >= NCH: write ignored.
  - A second write before apply overwrites the shadow; PEND stays 1.
- Apply (glitch-free switchover):
  - When: at the first edge strictly after the write where that channel has hit=1, or RUN[i]=0, or the active config is invalid.
  - Loads active <= shadow and clears PEND.
  - On a hit edge, the CE pulse and the acc subtraction use the old config; acc then becomes min-clamped: if the post-update acc >= new DIV, acc <= 0.
  - phase wraps to 0 if phase >= new NPH.
- Write and apply on the same edge for the same channel: the write wins; it becomes the new shadow and PEND stays 1.
- SYNC:
  - All channels: acc=0, phase=0, CE=0.
  - Any pending shadow is applied immediately and PEND cleared.
  - A CFG_WE on the same edge lands in the shadow with PEND=1.
- Mid-operation: RES or SYNC mid-pulse drops CE the next cycle; no partial pulses.

Decomposition:
- scv_pkg: add cegen_cfg_t struct {mul[W], div[W], nph[PW+1]}, localparams for the SCV defaults CEGEN_CPU4 (88/315), CEGEN_AUD (22/105), CEGEN_VDC (1/7), and a validity function cegen_cfg_valid.
- Sub-module frac_cegen_ch: one channel holding acc, phase, active/shadow config and PEND. It is instantiated NCH times via generate; the top handles write decode, SYNC fanout and output packing.

Test Plan:
- Reset defaults, RUN=4'b0001 -> CE[0]=1 every cycle from the cycle after RUN is sampled; PHASE[0] sequence 0,1,2,3,0; CE[3:1]=0; CFG_ERR=0.
- Ch0 write MUL=88 DIV=315 NPH=4 then SYNC -> exactly 88 CE pulses per 315 cycles; spacing only 3 or 4; PHASE cycles 0..3.
- Ch1 running 22/105; write 1/2 between pulses -> PEND[1]=1 until the next ch1 CE; that pulse is spaced per 22/105; after it, CE every 2nd cycle; PEND clears on the same edge.
- Ch2 write MUL=0, then MUL=5 DIV=3 -> CFG_ERR[2]=1, CE[2] stays 0; write 1/1 -> applied next edge (invalid config applies immediately), CFG_ERR[2]=0, CE resumes.
- Ch0=1/3 and ch1=1/3 with different history, pulse SYNC -> both emit CE on the same cycle, 3 cycles after SYNC, PHASE=0 on both.
- RES asserted during a CE pulse with PEND=1 -> next cycle CE=0, PEND=0, config back to 1/1, PHASE=0.
